lsu_mem_ctrl: RTL and testbench

- Load/store unit between the core's execute stage and the 64-bit data memory.
- Memory port writes only aligned 64-bit doublewords and reads combinationally.
- Accepts RV64 byte/half/word/double loads and stores over valid/ready; sub-doubleword stores become read-modify-write sequences; load data is sign/zero-extended.
- Misaligned, out-of-range or illegal-funct3 requests return an error and do not touch memory.

---
 rtl/lsu_mem_ctrl_if.sv | 29 ++
 rtl/lsu_mem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Core request/response handshake and 64-bit data-memory port of the load/store unit.
// slave = the LSU itself; master = the core/memory environment that drives it.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV64 load/store unit over a doubleword-only memory; sub-doubleword stores are read-modify-write.
// Optional LSU_STATS_EN adds saturating load/store/error response counters.
module lsu_mem_ctrl #(
    parameter int MEM_BYTES = 1024
) (
    input  logic          clk,
    input  logic          reset,
    lsu_mem_ctrl_if.slave bus
`ifdef LSU_STATS_EN
    ,
    output logic [31:0]   stat_loads,
    output logic [31:0]   stat_stores,
    output logic [31:0]   stat_errs
`endif
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      r_state;
    logic [2:0]  r_f3;
    logic [2:0]  r_off;
    logic [63:0] r_wdata;
    logic        r_req_ready, r_resp_valid, r_resp_err, r_mem_we, r_mem_re;
    logic [63:0] r_resp_rdata, r_mem_addr, r_mem_wdata;

    logic [3:0]  w_size;
    logic [64:0] w_end;
    logic        w_mis, w_bad_f3, w_err;

    // Accept-time legality, evaluated on the incoming request
    always_comb begin
        w_size   = 4'd1 << bus.req_funct3[1:0];
        w_end    = {1'b0, bus.req_addr} + {61'd0, w_size};
        w_bad_f3 = (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
        case (bus.req_funct3[1:0])
            2'b01:   w_mis = bus.req_addr[0];
            2'b10:   w_mis = |bus.req_addr[1:0];
            2'b11:   w_mis = |bus.req_addr[2:0];
            default: w_mis = 1'b0;
        endcase
        w_err = w_bad_f3 || w_mis || (w_end > 65'(MEM_BYTES));
    end

    logic [5:0]  w_sh;
    logic [63:0] w_lane, w_ext, w_lmask, w_mask, w_merged;

    always_comb begin
        w_sh   = {r_off, 3'b000};
        w_lane = bus.mem_rdata >> w_sh;
        case (r_f3)
            3'b000:  w_ext = {{56{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_ext = {{48{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_ext = {{32{w_lane[31]}}, w_lane[31:0]};
            3'b100:  w_ext = {56'd0, w_lane[7:0]};
            3'b101:  w_ext = {48'd0, w_lane[15:0]};
            3'b110:  w_ext = {32'd0, w_lane[31:0]};
            default: w_ext = w_lane;
        endcase
        case (r_f3[1:0])
            2'b00:   w_lmask = 64'h0000_0000_0000_00FF;
            2'b01:   w_lmask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_lmask = 64'h0000_0000_FFFF_FFFF;
            default: w_lmask = '1;
        endcase
        w_mask   = w_lmask << w_sh;
        w_merged = (bus.mem_rdata & ~w_mask) | ((r_wdata << w_sh) & w_mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_f3         <= '0;
            r_off        <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_f3        <= bus.req_funct3;
                    r_off       <= bus.req_addr[2:0];
                    r_wdata     <= bus.req_wdata;
                    r_req_ready <= 1'b0;
                    if (w_err) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end else begin
                        r_mem_addr <= {bus.req_addr[63:3], 3'b000};
                        if (!bus.req_we) begin
                            r_state  <= LOAD;
                            r_mem_re <= 1'b1;
                        end else if (bus.req_funct3 == 3'b011) begin
                            // Full doubleword store needs no read of the old contents
                            r_state     <= WRITE;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= bus.req_wdata;
                        end else begin
                            r_state  <= RMW_RD;
                            r_mem_re <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_mem_re     <= 1'b0;
                    r_resp_rdata <= w_ext;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RMW_RD: begin
                    r_mem_re    <= 1'b0;
                    r_mem_we    <= 1'b1;
                    r_mem_wdata <= w_merged;
                    r_state     <= WRITE;
                end
                WRITE: begin
                    r_mem_we     <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_re     = r_mem_re;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

`ifdef LSU_STATS_EN
    logic        r_st_store;
    logic [31:0] r_st_loads, r_st_stores, r_st_errs;
    logic        w_take;

    assign w_take = (r_state == RESP) && r_resp_valid && bus.resp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st_store  <= 1'b0;
            r_st_loads  <= '0;
            r_st_stores <= '0;
            r_st_errs   <= '0;
        end else begin
            if (r_state == IDLE && bus.req_valid) r_st_store <= bus.req_we;
            if (w_take) begin
                if (r_resp_err) begin
                    if (r_st_errs != '1) r_st_errs <= r_st_errs + 32'd1;
                end else if (r_st_store) begin
                    if (r_st_stores != '1) r_st_stores <= r_st_stores + 32'd1;
                end else begin
                    if (r_st_loads != '1) r_st_loads <= r_st_loads + 32'd1;
                end
            end
        end
    end

    assign stat_loads  = r_st_loads;
    assign stat_stores = r_st_stores;
    assign stat_errs   = r_st_errs;
`endif
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed plan steps then random traffic,
// scored against a byte-array reference memory.
module tb_lsu_mem_ctrl;
    localparam int MEMB = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if bif();
`ifdef LSU_STATS_EN
    logic [31:0] st_l, st_s, st_e;
    int exp_l, exp_s, exp_e;
`endif

    lsu_mem_ctrl #(.MEM_BYTES(MEMB)) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bif)
`ifdef LSU_STATS_EN
        ,
        .stat_loads (st_l),
        .stat_stores(st_s),
        .stat_errs  (st_e)
`endif
    );

    // Environment memory seen by the DUT
    logic [63:0] dmem [0:127] = '{0: 64'h5, default: 64'h0};
    assign bif.mem_rdata = dmem[bif.mem_addr[9:3]];
    always @(posedge clk) if (bif.mem_we) dmem[bif.mem_addr[9:3]] <= bif.mem_wdata;

    int we_cnt, re_cnt, both_cnt;
    logic [63:0] last_wd;
    always @(negedge clk) begin
        if (bif.mem_we) begin we_cnt++; last_wd = bif.mem_wdata; end
        if (bif.mem_re) re_cnt++;
        if (bif.mem_we && bif.mem_re) both_cnt++;
    end

    int checks, errors;
    logic [7:0] ref_mem [0:MEMB-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_dword(input logic [63:0] a);
        logic [63:0] d;
        int base;
        base = int'(a) & ~7;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = ref_mem[base+i];
        return d;
    endfunction

    function automatic void model(input logic we, input logic [2:0] f3, input logic [63:0] a,
                                  input logic [63:0] wd, output logic err, output logic [63:0] rd,
                                  output int lat, output int nwe, output int nre);
        int sz, ai;
        sz  = 1 << f3[1:0];
        err = (f3 == 3'b111) || (we && f3[2]) || (a % 64'(sz) != 0) || (a + 64'(sz) > 64'(MEMB));
        rd = '0; lat = 1; nwe = 0; nre = 0;
        if (!err) begin
            ai = int'(a);
            if (!we) begin
                for (int i = 0; i < sz; i++) rd[8*i +: 8] = ref_mem[ai+i];
                if (!f3[2] && sz < 8 && rd[8*sz-1]) rd = rd | (~64'd0 << (8*sz));
                lat = 2; nre = 1;
            end else begin
                for (int i = 0; i < sz; i++) ref_mem[ai+i] = wd[8*i +: 8];
                lat = (sz == 8) ? 2 : 3;
                nwe = 1;
                nre = (sz == 8) ? 0 : 1;
            end
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int hold, input string tag);
        logic e_err;
        logic [63:0] e_rd, rd0;
        int e_lat, e_we, e_re, lat, b_we, b_re;
        model(we, f3, a, wd, e_err, e_rd, e_lat, e_we, e_re);
        b_we = we_cnt; b_re = re_cnt;
        chk({tag, " req_ready"}, 64'(bif.req_ready), 64'd1);
        bif.req_valid = 1'b1; bif.req_we = we; bif.req_funct3 = f3;
        bif.req_addr = a; bif.req_wdata = wd;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        lat = 1;
        while (!bif.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk({tag, " latency"}, 64'(lat), 64'(e_lat));
        rd0 = bif.resp_rdata;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_funct3 = 3'b011;
                bif.req_addr = 64'd16; bif.req_wdata = '1;
            end
            if (i == 2) bif.req_valid = 1'b0;
            @(posedge clk); #1;
            chk({tag, " stall valid"}, 64'(bif.resp_valid), 64'd1);
            chk({tag, " stall rdata"}, bif.resp_rdata, rd0);
            chk({tag, " stall req_ready"}, 64'(bif.req_ready), 64'd0);
        end
        bif.req_valid = 1'b0;
        chk({tag, " err"}, 64'(bif.resp_err), 64'(e_err));
        chk({tag, " rdata"}, bif.resp_rdata, e_rd);
        bif.resp_ready = 1'b1;
        @(posedge clk); #1;
        bif.resp_ready = 1'b0;
        chk({tag, " resp_valid drop"}, 64'(bif.resp_valid), 64'd0);
        chk({tag, " back to idle"}, 64'(bif.req_ready), 64'd1);
        chk({tag, " mem_we cycles"}, 64'(we_cnt - b_we), 64'(e_we));
        chk({tag, " mem_re cycles"}, 64'(re_cnt - b_re), 64'(e_re));
        if (e_we != 0) chk({tag, " mem_wdata"}, last_wd, ref_dword(a));
`ifdef LSU_STATS_EN
        if (e_err) exp_e++; else if (we) exp_s++; else exp_l++;
`endif
    endtask

    initial begin
        int b;
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
        ref_mem[0] = 8'h05;
        bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_funct3 = 3'b000;
        bif.req_addr = '0; bif.req_wdata = '0; bif.resp_ready = 1'b0;
`ifdef LSU_STATS_EN
        exp_l = 0; exp_s = 0; exp_e = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset req_ready",  64'(bif.req_ready),  64'd1);
        chk("reset resp_valid", 64'(bif.resp_valid), 64'd0);
        chk("reset resp_err",   64'(bif.resp_err),   64'd0);
        chk("reset resp_rdata", bif.resp_rdata,      64'd0);
        chk("reset mem_we",     64'(bif.mem_we),     64'd0);
        chk("reset mem_re",     64'(bif.mem_re),     64'd0);
        chk("reset mem_addr",   bif.mem_addr,        64'd0);
        chk("reset mem_wdata",  bif.mem_wdata,       64'd0);

        do_req(1'b0, 3'b011, 64'd0, 64'd0, 0, "LD0");
        do_req(1'b1, 3'b000, 64'd3, 64'hFF, 0, "SB3");
        chk("SB3 merged word", last_wd, 64'h0000_0000_FF00_0005);
        do_req(1'b0, 3'b011, 64'd0, 64'd0, 0, "LD0 after SB");
        do_req(1'b0, 3'b000, 64'd3, 64'd0, 0, "LB3");
        do_req(1'b0, 3'b100, 64'd3, 64'd0, 0, "LBU3");
        do_req(1'b0, 3'b010, 64'd0, 64'd0, 0, "LW0");

        do_req(1'b0, 3'b001, 64'd1,    64'd0, 0, "LH1 misaligned");
        do_req(1'b1, 3'b011, 64'd4,    64'h1, 0, "SD4 misaligned");
        do_req(1'b0, 3'b011, 64'd1024, 64'd0, 0, "LD1024 range");
        do_req(1'b0, 3'b111, 64'd0,    64'd0, 0, "funct3 111");
        do_req(1'b1, 3'b100, 64'd0,    64'd0, 0, "store funct3 100");

        b = we_cnt;
        do_req(1'b0, 3'b011, 64'd0, 64'd0, 5, "LD stall");
        repeat (2) @(posedge clk); #1;
        chk("stall poke not accepted valid", 64'(bif.resp_valid), 64'd0);
        chk("stall poke no write", 64'(we_cnt - b), 64'd0);
        chk("stall poke mem untouched", dmem[2], 64'd0);

        b = we_cnt;
        bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_funct3 = 3'b001;
        bif.req_addr = 64'd8; bif.req_wdata = 64'h1234;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        chk("rst-mid in RMW read", 64'(bif.mem_re), 64'd1);
        rst = 1'b1; #1;
        chk("rst-mid req_ready",  64'(bif.req_ready),  64'd1);
        chk("rst-mid resp_valid", 64'(bif.resp_valid), 64'd0);
        chk("rst-mid mem_re",     64'(bif.mem_re),     64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst-mid no write", 64'(we_cnt - b), 64'd0);
        chk("rst-mid resp discarded", 64'(bif.resp_valid), 64'd0);
`ifdef LSU_STATS_EN
        exp_l = 0; exp_s = 0; exp_e = 0;
`endif
        do_req(1'b0, 3'b011, 64'd8, 64'd0, 0, "LD8 after reset");

        for (int k = 0; k < 60; k++) begin
            logic rwe;
            logic [2:0] rf3;
            logic [63:0] ra, rwd;
            int sz;
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            sz  = 1 << rf3[1:0];
            if ($urandom_range(0, 3) != 0) ra = 64'(int'($urandom_range(0, MEMB-1)) & ~(sz-1));
            else ra = 64'($urandom_range(0, MEMB+16));
            rwd = {$urandom, $urandom};
            do_req(rwe, rf3, ra, rwd, 0, "rnd");
        end

        chk("mem_we and mem_re never together", 64'(both_cnt), 64'd0);
`ifdef LSU_STATS_EN
        chk("stat_loads",  64'(st_l), 64'(exp_l));
        chk("stat_stores", 64'(st_s), 64'(exp_s));
        chk("stat_errs",   64'(st_e), 64'(exp_e));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
